// File: rtl/bram_pq_pkg.sv
// Shared types and constants for the BRAM-backed binary min-heap priority queue.
// Optional feature macro used by the top: BRAM_PQ_PEEK_EN.
package bram_pq_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 8;
    localparam int CAPACITY   = (1 << DEF_ADDR_W) - 1;
    localparam int ROOT_IDX   = 1;

    typedef enum logic [2:0] {
        IDLE,
        UP_RD,
        UP_CMP,
        DQ_RD_ROOT,
        DQ_RD_LAST,
        DN_RD_L,
        DN_RD_R,
        DN_CMP
    } state_t;

endpackage

// File: rtl/bram_pq_store.sv
// Heap storage: 2**ADDR_W x DATA_W simple dual-port RAM, synchronous write and
// registered read, shaped for block-RAM inference.
module bram_pq_store #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] r_rdata;

    // NOTE: the array gets no reset; a reset port would stop block-RAM inference, and occupancy alone defines valid slots.
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/bram_heap_pq.sv
// Binary min-heap priority queue engine over a 1R/1W registered-read RAM.
// Define BRAM_PQ_PEEK_EN to add peek_valid/peek_data (shadow copy of the root).
module bram_heap_pq
    import bram_pq_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enq_req,
    input  logic [DATA_W-1:0] enq_data,
    input  logic              deq_req,
    output logic              ready,
    output logic              deq_valid,
    output logic [DATA_W-1:0] deq_data,
    output logic [ADDR_W-1:0] count,
    output logic              empty,
    output logic              full
`ifdef BRAM_PQ_PEEK_EN
    ,
    output logic              peek_valid,
    output logic [DATA_W-1:0] peek_data
`endif
);

    localparam logic [ADDR_W-1:0] ROOT_A = ADDR_W'(ROOT_IDX);
    localparam logic [ADDR_W-1:0] CAP_A  = ADDR_W'((1 << ADDR_W) - 1);

    state_t r_state, w_next;
    logic [ADDR_W-1:0] r_idx, r_count;
    logic [DATA_W-1:0] r_val, r_lval, r_deq_data;
    logic              r_first, r_has_r, r_deq_valid;

    logic              w_we, w_re;
    logic [ADDR_W-1:0] w_waddr, w_raddr;
    logic [DATA_W-1:0] w_wdata, w_rdata;

    bram_pq_store #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_store (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_re    (w_re),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    assign ready     = (r_state == IDLE);
    assign empty     = (r_count == '0);
    assign full      = (r_count == CAP_A);
    assign count     = r_count;
    assign deq_valid = r_deq_valid;
    assign deq_data  = r_deq_data;

    logic w_deq_take, w_enq_take;
    assign w_deq_take = ready && deq_req && !empty;
    assign w_enq_take = ready && enq_req && !deq_req && !full;

    // Child indices carry one extra bit so 2*idx never wraps past the last slot.
    logic [ADDR_W:0] w_l, w_r;
    logic            w_l_ok, w_r_ok, w_sel_r;
    logic [DATA_W-1:0] w_cur_val, w_c_val;
    logic [ADDR_W-1:0] w_c_idx;

    assign w_l       = {r_idx, 1'b0};
    assign w_r       = {r_idx, 1'b1};
    assign w_l_ok    = (w_l <= {1'b0, r_count});
    assign w_r_ok    = (w_r <= {1'b0, r_count});
    assign w_cur_val = r_first ? w_rdata : r_val;
    assign w_sel_r   = r_has_r && (w_rdata < r_lval);
    assign w_c_val   = w_sel_r ? w_rdata : r_lval;
    assign w_c_idx   = w_sel_r ? w_r[ADDR_W-1:0] : w_l[ADDR_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path leaves one unassigned and infers a latch.
        w_next  = r_state;
        w_we    = 1'b0;
        w_waddr = r_idx;
        w_wdata = r_val;
        w_re    = 1'b0;
        w_raddr = '0;
        unique case (r_state)
            IDLE: begin
                if (w_deq_take)      w_next = DQ_RD_ROOT;
                else if (w_enq_take) w_next = UP_RD;
            end
            UP_RD: begin
                if (r_idx == ROOT_A) begin
                    w_we   = 1'b1;
                    w_next = IDLE;
                end else begin
                    w_re    = 1'b1;
                    w_raddr = r_idx >> 1;
                    w_next  = UP_CMP;
                end
            end
            UP_CMP: begin
                w_we = 1'b1;
                if (w_rdata > r_val) begin
                    w_wdata = w_rdata;
                    w_next  = UP_RD;
                end else begin
                    w_next  = IDLE;
                end
            end
            DQ_RD_ROOT: begin
                w_re    = 1'b1;
                w_raddr = ROOT_A;
                w_next  = DQ_RD_LAST;
            end
            DQ_RD_LAST: begin
                if (r_count == ROOT_A) begin
                    w_next = IDLE;
                end else begin
                    w_re    = 1'b1;
                    w_raddr = r_count;
                    w_next  = DN_RD_L;
                end
            end
            DN_RD_L: begin
                if (!w_l_ok) begin
                    w_we    = 1'b1;
                    w_wdata = w_cur_val;
                    w_next  = IDLE;
                end else begin
                    w_re    = 1'b1;
                    w_raddr = w_l[ADDR_W-1:0];
                    w_next  = DN_RD_R;
                end
            end
            DN_RD_R: begin
                w_re    = w_r_ok;
                w_raddr = w_r[ADDR_W-1:0];
                w_next  = DN_CMP;
            end
            DN_CMP: begin
                w_we = 1'b1;
                if (w_c_val < r_val) begin
                    w_wdata = w_c_val;
                    w_next  = DN_RD_L;
                end else begin
                    w_next  = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= ROOT_A;
            r_count     <= '0;
            r_val       <= '0;
            r_lval      <= '0;
            r_first     <= 1'b0;
            r_has_r     <= 1'b0;
            r_deq_valid <= 1'b0;
            r_deq_data  <= '0;
        end else begin
            r_deq_valid <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_deq_take) begin
                        r_idx <= ROOT_A;
                    end else if (w_enq_take) begin
                        r_val   <= enq_data;
                        r_idx   <= r_count + ADDR_W'(1);
                        r_count <= r_count + ADDR_W'(1);
                    end
                end
                UP_CMP: if (w_rdata > r_val) r_idx <= r_idx >> 1;
                DQ_RD_LAST: begin
                    r_deq_valid <= 1'b1;
                    r_deq_data  <= w_rdata;
                    r_count     <= r_count - ADDR_W'(1);
                    r_first     <= 1'b1;
                    r_idx       <= ROOT_A;
                end
                DN_RD_L: begin
                    r_val   <= w_cur_val;
                    r_first <= 1'b0;
                end
                DN_RD_R: begin
                    r_lval  <= w_rdata;
                    r_has_r <= w_r_ok;
                end
                DN_CMP: if (w_c_val < r_val) r_idx <= w_c_idx;
                default: ;
            endcase
        end
    end

`ifdef BRAM_PQ_PEEK_EN
    logic [DATA_W-1:0] r_peek;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        r_peek <= '0;
        else if (w_we && w_waddr == ROOT_A) r_peek <= w_wdata;
    end

    assign peek_valid = !empty;
    assign peek_data  = r_peek;
`else
    // Without peek the root is only observable through a dequeue.
`endif

endmodule

// File: tb/tb_bram_heap_pq.sv
// Self-checking bench for bram_heap_pq: table-driven enq/deq vectors plus
// hand-written sequences for fill, collision, mid-op reset and optional peek.
module tb_bram_heap_pq;

    logic       clk = 1'b0;
    logic       rst_n, enq_req, deq_req;
    logic [7:0] enq_data;
    logic       ready, deq_valid, empty, full;
    logic [7:0] deq_data, count;
`ifdef BRAM_PQ_PEEK_EN
    logic       peek_valid;
    logic [7:0] peek_data;
`endif

    bram_heap_pq #(.DATA_W(8), .ADDR_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enq_req   (enq_req),
        .enq_data  (enq_data),
        .deq_req   (deq_req),
        .ready     (ready),
        .deq_valid (deq_valid),
        .deq_data  (deq_data),
        .count     (count),
        .empty     (empty),
        .full      (full)
`ifdef BRAM_PQ_PEEK_EN
        ,
        .peek_valid(peek_valid),
        .peek_data (peek_data)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       is_deq;
        logic [7:0] din;
        logic [7:0] exp_data;
        logic [7:0] exp_count;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!ready) check({name, " ready timeout"}, ready, 1);
    endtask

    task automatic do_enq(input logic [7:0] v);
        wait_ready("enq pre");
        enq_req  = 1'b1;
        enq_data = v;
        @(negedge clk);
        enq_req  = 1'b0;
        wait_ready("enq post");
    endtask

    // lat counts cycles from the accepting edge to the edge raising deq_valid.
    task automatic do_deq(output logic [7:0] v, output int lat);
        wait_ready("deq pre");
        deq_req = 1'b1;
        @(negedge clk);
        deq_req = 1'b0;
        lat = 0;
        while (!deq_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!deq_valid) check("deq_valid timeout", deq_valid, 1);
        v = deq_data;
    endtask

    task automatic run_vecs(input string tag);
        logic [7:0] v;
        int lat;
        foreach (vecs[i]) begin
            if (vecs[i].is_deq) begin
                do_deq(v, lat);
                check({tag, " deq_data"}, v, vecs[i].exp_data);
                check({tag, " deq count"}, count, vecs[i].exp_count);
                if (i == 0 || !vecs[i-1].is_deq) check({tag, " deq latency"}, lat, 2);
                wait_ready("deq post");
            end else begin
                do_enq(vecs[i].din);
                check({tag, " enq count"}, count, vecs[i].exp_count);
            end
        end
        check({tag, " empty at end"}, empty, 1);
        vecs.delete();
    endtask

    function automatic vec_t mk(input logic d, input logic [7:0] din, input logic [7:0] ed,
                                input logic [7:0] ec);
        vec_t r;
        r.is_deq = d; r.din = din; r.exp_data = ed; r.exp_count = ec;
        return r;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v;
        int lat;
        logic [7:0] model[$];

        rst_n = 1'b0; enq_req = 1'b0; deq_req = 1'b1; enq_data = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset deq_valid", deq_valid, 0);
            check("reset ready", ready, 1);
        end
        check("reset empty", empty, 1);
        check("reset count", count, 0);
        check("reset full", full, 0);
        check("reset deq_data", deq_data, 0);
        deq_req = 1'b0;

        vecs.push_back(mk(0, 5, 0, 1)); vecs.push_back(mk(0, 3, 0, 2));
        vecs.push_back(mk(0, 9, 0, 3)); vecs.push_back(mk(0, 1, 0, 4));
        vecs.push_back(mk(0, 7, 0, 5));
        vecs.push_back(mk(1, 0, 1, 4)); vecs.push_back(mk(1, 0, 3, 3));
        vecs.push_back(mk(1, 0, 5, 2)); vecs.push_back(mk(1, 0, 7, 1));
        vecs.push_back(mk(1, 0, 9, 0));
        run_vecs("basic");

        vecs.push_back(mk(0, 4, 0, 1)); vecs.push_back(mk(0, 4, 0, 2));
        vecs.push_back(mk(0, 2, 0, 3)); vecs.push_back(mk(0, 4, 0, 4));
        vecs.push_back(mk(1, 0, 2, 3)); vecs.push_back(mk(1, 0, 4, 2));
        vecs.push_back(mk(1, 0, 4, 1)); vecs.push_back(mk(1, 0, 4, 0));
        run_vecs("ties");

        // Fill to capacity with random keys, then drain and compare to a sorted model.
        for (int i = 0; i < 255; i++) begin
            v = 8'($urandom_range(0, 255));
            model.push_back(v);
            do_enq(v);
        end
        check("fill full", full, 1);
        check("fill count", count, 255);
        enq_req = 1'b1; enq_data = 8'h00;
        @(negedge clk);
        check("enq when full ready", ready, 1);
        check("enq when full count", count, 255);
        enq_req = 1'b0;
        model.sort();
        for (int i = 0; i < 255; i++) begin
            do_deq(v, lat);
            check("drain order", v, model[i]);
            if (i == 254) check("drain count", count, 0);
            wait_ready("drain post");
        end
        check("drain empty", empty, 1);
        check("drain full", full, 0);

        // Simultaneous requests: dequeue wins, held enqueue is taken afterwards.
        do_enq(10); do_enq(20); do_enq(30);
        enq_req = 1'b1; enq_data = 8'd5; deq_req = 1'b1;
        @(negedge clk);
        deq_req = 1'b0;
        lat = 0;
        while (!deq_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("both deq_valid", deq_valid, 1);
        check("both deq_data", deq_data, 10);
        check("both count", count, 2);
        wait_ready("both wait");
        @(negedge clk);
        enq_req = 1'b0;
        check("held enq taken", ready, 0);
        check("held enq count", count, 3);
        wait_ready("held enq post");
        do_deq(v, lat); check("both tail 0", v, 5);  wait_ready("t0");
        do_deq(v, lat); check("both tail 1", v, 20); wait_ready("t1");
        do_deq(v, lat); check("both tail 2", v, 30); wait_ready("t2");

        // Reset during sift-down abandons the operation.
        do_enq(3); do_enq(8); do_enq(5); do_enq(9); do_enq(12); do_enq(6); do_enq(7);
        deq_req = 1'b1;
        @(negedge clk);
        deq_req = 1'b0;
        repeat (3) @(negedge clk);
        check("pre-reset busy", ready, 0);
        rst_n = 1'b0;
        #2;
        check("mid reset ready", ready, 1);
        check("mid reset count", count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post reset ready", ready, 1);
        check("post reset empty", empty, 1);
        do_enq(6);
        do_deq(v, lat);
        check("post reset deq", v, 6);
        wait_ready("post reset");

`ifdef BRAM_PQ_PEEK_EN
        do_enq(8); do_enq(2);
        check("peek valid", peek_valid, 1);
        check("peek after enq", peek_data, 2);
        do_deq(v, lat); wait_ready("peek deq1");
        check("peek deq1 data", v, 2);
        check("peek after deq", peek_data, 8);
        do_deq(v, lat); wait_ready("peek deq2");
        check("peek deq2 data", v, 8);
        check("peek valid empty", peek_valid, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
